hs_merge2: RTL and testbench

- Clocked 2-to-1 merge with a full four-phase request/acknowledge handshake on each input.
- Replaces feedback-less request-edge muxing. Each producer holds its data until it is acknowledged, so no word is lost or duplicated.
- Sits between two request-driven producers (request lines may be asynchronous to clk) and a single valid/ready consumer.
- Simultaneous requests are arbitrated round-robin.

---
 rtl/hs_merge2.sv | 91 +++++++++
 tb/tb_hs_merge2.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_merge2.sv
// Two-input merge: each producer speaks four-phase req/ack, the consumer sees a
// registered valid/ready word tagged with its source; ties alternate between inputs.
module hs_merge2 #(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
    parameter int               SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    output logic             ack1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in2,
    output logic             ack2,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [SYNC_STAGES-1:0] sync1;
    logic [SYNC_STAGES-1:0] sync2;
    logic                   s1;
    logic                   s2;
    logic                   pend1;
    logic                   pend2;
    logic                   slot_free;
    logic                   grant1;
    logic                   grant2;
    logic                   last_was2;

    // Request synchronizers: the last flop of each chain is the only one used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sync1[SYNC_STAGES-2:0], req1};
            sync2 <= {sync2[SYNC_STAGES-2:0], req2};
        end
    end

    assign s1 = sync1[SYNC_STAGES-1];
    assign s2 = sync2[SYNC_STAGES-1];

    // A request counts only while its ack is low, so one capture per four-phase cycle.
    assign pend1     = s1 & ~ack1;
    assign pend2     = s2 & ~ack2;
    assign slot_free = ~out_valid | out_ready;

    // Round-robin tie break: the input that did not win last time goes first.
    assign grant1 = slot_free & pend1 & (~pend2 | last_was2);
    assign grant2 = slot_free & pend2 & (~pend1 | ~last_was2);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= DEFAULT_VALUE;
            out_src   <= 1'b0;
            ack1      <= 1'b0;
            ack2      <= 1'b0;
            last_was2 <= 1'b1;
        end else begin
            if (grant1) begin
                out_data  <= in1;
                out_src   <= 1'b0;
                out_valid <= 1'b1;
                ack1      <= 1'b1;
                last_was2 <= 1'b0;
            end else if (grant2) begin
                out_data  <= in2;
                out_src   <= 1'b1;
                out_valid <= 1'b1;
                ack2      <= 1'b1;
                last_was2 <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Ack is released once the synchronized request has gone low.
            if (ack1 && !s1) begin
                ack1 <= 1'b0;
            end
            if (ack2 && !s2) begin
                ack2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hs_merge2.sv
// Bench for hs_merge2: directed handshake/arbitration scenarios, then random
// four-phase producers against per-source expected-word queues.
module tb_hs_merge2;

    localparam int             W   = 8;
    localparam logic [W-1:0]   DEF = 8'h5A;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req1 = 1'b0;
    logic         req2 = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         out_ready = 1'b0;
    logic         ack1;
    logic         ack2;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_valid;

    int total  = 0;
    int passed = 0;

    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic         done0 = 1'b0;
    logic         done1 = 1'b0;

    hs_merge2 #(.WIDTH(W), .DEFAULT_VALUE(DEF), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .req1(req1), .in1(in1), .ack1(ack1),
        .req2(req2), .in2(in2), .ack2(ack2),
        .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ackv(input int src);
        return (src == 0) ? ack1 : ack2;
    endfunction

    // Monitor: every accepted word must be the oldest outstanding word of its source,
    // and a stalled word must not move.
    logic         stall_prev = 1'b0;
    logic [W-1:0] data_prev  = '0;
    logic         src_prev   = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_data", 32'(out_data), 32'(data_prev));
                chk("hold_src", 32'(out_src), 32'(src_prev));
            end
            if (out_valid && out_ready) begin
                if (out_src == 1'b0) begin
                    if (q1.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_word_src0: got %0h expected none", out_data);
                    end else begin
                        e = q1.pop_front();
                        chk("word_src0", 32'(out_data), 32'(e));
                    end
                end else begin
                    if (q2.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_word_src1: got %0h expected none", out_data);
                    end else begin
                        e = q2.pop_front();
                        chk("word_src1", 32'(out_data), 32'(e));
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            src_prev   = out_src;
        end
    end

    task automatic producer(input int src, input int n);
        logic [W-1:0] d;
        int t;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 4)) tick();
            d = W'($urandom);
            if (src == 0) begin q1.push_back(d); in1 = d; req1 = 1'b1; end
            else          begin q2.push_back(d); in2 = d; req2 = 1'b1; end
            t = 0;
            while (!ackv(src) && t < 300) begin tick(); t++; end
            chk("rand_ack_rise", 32'(ackv(src)), 32'(1));
            repeat ($urandom_range(0, 3)) tick();
            if (src == 0) req1 = 1'b0; else req2 = 1'b0;
            t = 0;
            while (ackv(src) && t < 50) begin tick(); t++; end
            chk("rand_ack_fall", 32'(ackv(src)), 32'(0));
        end
        if (src == 0) done0 = 1'b1; else done1 = 1'b1;
    endtask

    initial begin
        logic ok;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_data", 32'(out_data), 32'(DEF));
        chk("rst_src", 32'(out_src), 32'(0));
        chk("rst_ack1", 32'(ack1), 32'(0));
        chk("rst_ack2", 32'(ack2), 32'(0));
        rst = 1'b0;
        tick();
        chk("idle_data", 32'(out_data), 32'(DEF));

        // First tie after reset: in1 wins, in2 follows with no bubble
        out_ready = 1'b1;
        in1 = 8'h0A; in2 = 8'h0B; q1.push_back(8'h0A); q2.push_back(8'h0B);
        req1 = 1'b1; req2 = 1'b1;
        tick(); tick();
        chk("tie1_early", 32'(out_valid), 32'(0));
        tick();
        chk("tie1_first_src", 32'(out_src), 32'(0));
        chk("tie1_first_data", 32'(out_data), 32'(8'h0A));
        chk("tie1_ack2_wait", 32'(ack2), 32'(0));
        tick();
        chk("tie1_second_src", 32'(out_src), 32'(1));
        chk("tie1_second_data", 32'(out_data), 32'(8'h0B));
        chk("tie1_no_bubble", 32'(out_valid), 32'(1));
        req1 = 1'b0; req2 = 1'b0;
        repeat (5) tick();
        chk("tie1_released", 32'({ack1, ack2, out_valid}), 32'(0));

        // Single transfer: 3-edge latency, 3-edge release, no second capture
        in1 = 8'h11; q1.push_back(8'h11); req1 = 1'b1;
        tick(); tick();
        chk("single_ack_early", 32'(ack1), 32'(0));
        tick();
        chk("single_ack", 32'(ack1), 32'(1));
        chk("single_valid", 32'(out_valid), 32'(1));
        chk("single_data", 32'(out_data), 32'(8'h11));
        chk("single_src", 32'(out_src), 32'(0));
        req1 = 1'b0;
        tick(); tick();
        chk("single_ack_hold", 32'(ack1), 32'(1));
        tick();
        chk("single_ack_drop", 32'(ack1), 32'(0));
        repeat (4) tick();
        chk("single_no_dup", 32'(out_valid), 32'(0));

        // Tie after in1 was granted last: in2 goes first
        in1 = 8'h0C; in2 = 8'h0D; q1.push_back(8'h0C); q2.push_back(8'h0D);
        req1 = 1'b1; req2 = 1'b1;
        repeat (3) tick();
        chk("tie2_first_src", 32'(out_src), 32'(1));
        chk("tie2_first_data", 32'(out_data), 32'(8'h0D));
        tick();
        chk("tie2_second_src", 32'(out_src), 32'(0));
        chk("tie2_second_data", 32'(out_data), 32'(8'h0C));
        req1 = 1'b0; req2 = 1'b0;
        repeat (5) tick();

        // Backpressure: word held, pending in2 not acked, then loaded on the ready edge
        out_ready = 1'b0;
        in1 = 8'h31; q1.push_back(8'h31); req1 = 1'b1;
        tick();
        in2 = 8'h3B; q2.push_back(8'h3B); req2 = 1'b1;
        tick(); tick();
        chk("bp_first_data", 32'(out_data), 32'(8'h31));
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_data !== 8'h31 || out_valid !== 1'b1 || ack2 !== 1'b0) ok = 1'b0;
        end
        chk("bp_hold_10", 32'(ok), 32'(1));
        out_ready = 1'b1;
        tick();
        chk("bp_load_data", 32'(out_data), 32'(8'h3B));
        chk("bp_load_src", 32'(out_src), 32'(1));
        chk("bp_load_valid", 32'(out_valid), 32'(1));
        chk("bp_load_ack2", 32'(ack2), 32'(1));
        req1 = 1'b0; req2 = 1'b0;
        repeat (6) tick();
        chk("bp_drained", 32'(out_valid), 32'(0));

        // Reset mid-operation discards the held word; a still-high req is recaptured
        out_ready = 1'b0;
        in1 = 8'h77; q1.push_back(8'h77); req1 = 1'b1;
        repeat (3) tick();
        chk("midrst_pre_ack", 32'(ack1), 32'(1));
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_data", 32'(out_data), 32'(DEF));
        chk("midrst_ack1", 32'(ack1), 32'(0));
        q1.delete(); q2.delete();
        q1.push_back(8'h77);
        rst = 1'b0;
        tick(); tick();
        chk("recap_early", 32'(out_valid), 32'(0));
        tick();
        chk("recap_valid", 32'(out_valid), 32'(1));
        chk("recap_data", 32'(out_data), 32'(8'h77));
        out_ready = 1'b1;
        req1 = 1'b0;
        repeat (6) tick();

        // Random producers with random consumer stalls
        fork
            producer(0, 25);
            producer(1, 25);
            begin
                while (!(done0 && done1)) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) tick();
        chk("rand_q1_empty", 32'(q1.size()), 32'(0));
        chk("rand_q2_empty", 32'(q2.size()), 32'(0));
        chk("rand_idle", 32'(out_valid), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
